// File: rtl/pb_irq_pkg.sv
// Shared definitions for the PicoBlaze interrupt controller: FSM encodings,
// register offsets and VEC register bit positions.
package pb_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VEC  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam int VEC_ACTIVE = 7;
  localparam int VEC_ERR    = 6;

  localparam int CNT_W = 10;
  localparam logic [2:0] SPURIOUS_IDX = 3'd7;

endpackage

// File: rtl/pb_irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous event input, followed by a
// registered single-cycle rising-edge pulse.
module pb_irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic pulse
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      // stage 0/1: metastability filter
      meta_p0 <= src;
      sync_p1 <= meta_p0;
      // stage 2: edge detect, registered so PEND sets one cycle later
      prev_p2 <= sync_p1;
      pulse   <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/pb_irq_ctrl.sv
// Fixed-priority interrupt controller for the kcpsm3 PicoBlaze interrupt input.
// Optional ack timeout enabled by defining PB_IRQ_TIMEOUT_EN.
module pb_irq_ctrl
  import pb_irq_pkg::*;
#(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'hE0,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_data,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] edge_p;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] enabled;
  logic [N_SRC-1:0] sel_vec;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c;
  logic [2:0]       sel_idx;
  logic [2:0]       idx_q, idx_d;
  logic             active_q, active_d;
  logic             any_en;
  logic             err;
  logic [7:0]       offset;
  logic             hit;
  logic [1:0]       reg_sel;
  logic             wr_pend, wr_mask, wr_eoi;
  logic [7:0]       rd_d;
  logic [8:0]       unused_inputs;

  assign unused_inputs = {read_strobe, out_port};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    pb_irq_sync_edge u_sync_edge (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[g]),
      .pulse (edge_p[g])
    );
  end

  // Subtracting the base lets the window straddle any alignment.
  assign offset  = port_id - BASE_ADDR;
  assign hit     = (offset[7:2] == 6'd0);
  assign reg_sel = offset[1:0];
  assign wr_pend = write_strobe && hit && (reg_sel == REG_PEND);
  assign wr_mask = write_strobe && hit && (reg_sel == REG_MASK);
  assign wr_eoi  = write_strobe && hit && (reg_sel == REG_EOI);

  assign enabled   = pend_q & mask_q;
  assign any_en    = |enabled;
  assign interrupt = (state_q == REQ);

  // Lowest index wins: scan downwards so the last match is the smallest.
  always_comb begin
    sel_idx = 3'd0;
    sel_vec = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        sel_idx    = 3'(i);
        sel_vec    = '0;
        sel_vec[i] = 1'b1;
      end
    end
  end

`ifdef PB_IRQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign err = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    active_d = active_q;
    ack_clr  = '0;
`ifdef PB_IRQ_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
    if (wr_eoi) err_d = 1'b0;
`endif
    if (wr_mask) mask_d = out_port[N_SRC-1:0];

    case (state_q)
      IDLE: begin
        if (any_en) begin
          state_d = REQ;
`ifdef PB_IRQ_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          state_d = SERVICE;
          if (any_en) begin
            active_d = 1'b1;
            idx_d    = sel_idx;
            ack_clr  = sel_vec;
          end else begin
            active_d = 1'b0;
            idx_d    = SPURIOUS_IDX;
          end
        end
`ifdef PB_IRQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge is ORed in last so it survives a same-cycle clear.
    w1c    = wr_pend ? out_port[N_SRC-1:0] : '0;
    pend_d = (pend_q & ~w1c & ~ack_clr) | edge_p;
  end

  always_comb begin
    rd_d = 8'h00;
    if (hit) begin
      case (reg_sel)
        REG_PEND: rd_d = 8'(pend_q);
        REG_MASK: rd_d = 8'(mask_q);
        REG_VEC:  rd_d = {active_q, err, 3'b000, idx_q};
        default:  rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      mask_q   <= '0;
      idx_q    <= 3'd0;
      active_q <= 1'b0;
      in_data  <= 8'h00;
`ifdef PB_IRQ_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      in_data  <= rd_d;
`ifdef PB_IRQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Directed self-checking bench for pb_irq_ctrl (default parameters).
module tb_pb_irq_ctrl;

  localparam logic [7:0] A_PEND = 8'hE0;
  localparam logic [7:0] A_MASK = 8'hE1;
  localparam logic [7:0] A_VEC  = 8'hE2;
  localparam logic [7:0] A_EOI  = 8'hE3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq_src = 8'h00;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_data;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] rdata;
  int cycles;

  pb_irq_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_data       (in_data),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id = addr;
    out_port = data;
    write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    port_id = addr;
    read_strobe = 1'b1;
    tick(1);
    read_strobe = 1'b0;
    data = in_data;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
  endtask

  initial begin
    tick(2);
    check("reset_int", interrupt, 1'b0);
    check("reset_in_data", in_data, 8'h00);
    reset = 1'b1;
    tick(1);
    rd(A_PEND, rdata); check("reset_pend", rdata, 8'h00);
    rd(A_MASK, rdata); check("reset_mask", rdata, 8'h00);
    rd(A_VEC, rdata);  check("reset_vec", rdata, 8'h00);

    // 1: single source, latency, ack and EOI
    wr(A_MASK, 8'h04);
    irq_src[2] = 1'b1;
    tick(4);
    check("t1_int_t3", interrupt, 1'b0);
    tick(1);
    check("t1_int_t4", interrupt, 1'b1);
    rd(A_PEND, rdata); check("t1_pend", rdata, 8'h04);
    ack();
    check("t1_int_ack", interrupt, 1'b0);
    rd(A_VEC, rdata);  check("t1_vec", rdata, 8'h82);
    rd(A_PEND, rdata); check("t1_pend_clr", rdata, 8'h00);
    wr(A_EOI, 8'h5A);
    rd(A_VEC, rdata);  check("t1_vec_eoi", rdata, 8'h02);
    rd(8'hE4, rdata);  check("t1_undecoded", rdata, 8'h00);

    // 2: simultaneous sources, priority and back-to-back
    irq_src = 8'h00;
    tick(3);
    wr(A_MASK, 8'hFF);
    irq_src = 8'h22;
    tick(5);
    check("t2_int", interrupt, 1'b1);
    ack();
    rd(A_VEC, rdata); check("t2_vec1", rdata, 8'h81);
    wr(A_EOI, 8'h00);
    check("t2_int_eoi", interrupt, 1'b0);
    tick(1);
    check("t2_int_rerise", interrupt, 1'b1);
    ack();
    rd(A_VEC, rdata); check("t2_vec2", rdata, 8'h85);
    wr(A_EOI, 8'h00);
    rd(A_PEND, rdata); check("t2_pend", rdata, 8'h00);

    // 3: masked pending, unmask, W1C in REQ, spurious ack
    irq_src = 8'h00;
    wr(A_MASK, 8'h00);
    tick(3);
    irq_src[3] = 1'b1;
    tick(5);
    check("t3_int_masked", interrupt, 1'b0);
    rd(A_PEND, rdata); check("t3_pend", rdata, 8'h08);
    wr(A_MASK, 8'h08);
    check("t3_int_wr", interrupt, 1'b0);
    tick(1);
    check("t3_int_unmask", interrupt, 1'b1);
    wr(A_PEND, 8'h08);
    rd(A_PEND, rdata); check("t3_pend_w1c", rdata, 8'h00);
    ack();
    check("t3_int_ack", interrupt, 1'b0);
    rd(A_VEC, rdata); check("t3_vec_spur", rdata, 8'h07);
    wr(A_EOI, 8'h00);

    // 4: edge vs W1C collision, re-trigger of in-service source
    irq_src = 8'h00;
    wr(A_MASK, 8'h00);
    tick(3);
    irq_src[0] = 1'b1;
    tick(3);
    wr(A_PEND, 8'h01);
    rd(A_PEND, rdata); check("t4_set_wins", rdata, 8'h01);
    wr(A_MASK, 8'h01);
    tick(1);
    check("t4_int", interrupt, 1'b1);
    ack();
    rd(A_VEC, rdata); check("t4_vec", rdata, 8'h80);
    irq_src[0] = 1'b0;
    tick(3);
    irq_src[0] = 1'b1;
    tick(5);
    check("t4_int_service", interrupt, 1'b0);
    rd(A_PEND, rdata); check("t4_pend_reset", rdata, 8'h01);
    wr(A_EOI, 8'h00);
    tick(1);
    check("t4_reint", interrupt, 1'b1);
    ack();
    rd(A_VEC, rdata); check("t4_vec2", rdata, 8'h80);
    wr(A_EOI, 8'h00);

    // 5: reset in REQ and in SERVICE
    irq_src = 8'h00;
    tick(3);
    wr(A_MASK, 8'h02);
    irq_src[1] = 1'b1;
    tick(5);
    check("t5_int_req", interrupt, 1'b1);
    irq_src = 8'h00;
    #2 reset = 1'b0;
    #1;
    check("t5_int_rst_req", interrupt, 1'b0);
    check("t5_in_data_rst_req", in_data, 8'h00);
    tick(2);
    reset = 1'b1;
    rd(A_PEND, rdata); check("t5_pend", rdata, 8'h00);
    rd(A_MASK, rdata); check("t5_mask", rdata, 8'h00);
    wr(A_MASK, 8'h02);
    irq_src[1] = 1'b1;
    tick(5);
    ack();
    rd(A_VEC, rdata); check("t5_vec_service", rdata, 8'h81);
    irq_src = 8'h00;
    tick(1);
    #2 reset = 1'b0;
    #1;
    check("t5_int_rst_svc", interrupt, 1'b0);
    check("t5_in_data_rst_svc", in_data, 8'h00);
    tick(1);
    reset = 1'b1;
    rd(A_VEC, rdata); check("t5_vec_idle", rdata, 8'h00);
    wr(A_MASK, 8'h02);
    irq_src[1] = 1'b1;
    tick(5);
    check("t5_int_after", interrupt, 1'b1);
    ack();
    wr(A_EOI, 8'h00);

    // 6: unacknowledged request
    irq_src = 8'h00;
    tick(3);
    wr(A_MASK, 8'h01);
    irq_src[0] = 1'b1;
    tick(5);
    check("t6_int", interrupt, 1'b1);
`ifdef PB_IRQ_TIMEOUT_EN
    cycles = 0;
    while (interrupt && cycles < 2000) begin
      tick(1);
      cycles++;
    end
    check("t6_timeout_cycles", cycles, 1023);
    rd(A_VEC, rdata); check("t6_err_set", rdata[6], 1'b1);
    check("t6_rerequest", interrupt, 1'b1);
    wr(A_EOI, 8'h00);
    rd(A_VEC, rdata); check("t6_err_clr", rdata[6], 1'b0);
`else
    cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (interrupt) cycles++;
    end
    check("t6_held_cycles", cycles, 5000);
    rd(A_VEC, rdata); check("t6_err_zero", rdata[6], 1'b0);
`endif
    ack();
    rd(A_VEC, rdata); check("t6_vec", rdata, 8'h80);
    wr(A_EOI, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
